best_move_sel: RTL and testbench

- Sequential arg-max stage for the tic-tac-toe move chooser.
- Accepts one candidate score per board cell over a valid/ready stream, skips occupied cells, and keeps a running maximum.
- Presents the winning cell index and score to the move-commit logic through a valid/ready output handshake.
- The score comparison is done by the existing parameterized magnitude comparator MagComp.

---
 rtl/tictac_pkg.sv | 14 +
 rtl/best_move_sel_magcomp.sv | 34 +++
 rtl/best_move_sel.sv | 130 +++++++++++++
 tb/tb_best_move_sel.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/tictac_pkg.sv
// Shared types and sizing for the tic-tac-toe move chooser.
//   bms_state_t : state encoding of the best-move arg-max stage
//   N_CELLS     : board cells scanned per search
//   IDX_W       : width of a cell index ($clog2(N_CELLS))
//   SCORE_W     : width of an unsigned cell score
package tictac_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} bms_state_t;

  localparam int N_CELLS = 9;
  localparam int IDX_W   = 4;
  localparam int SCORE_W = 8;

endpackage

// File: rtl/best_move_sel_magcomp.sv
// MagComp: combinational unsigned magnitude comparator.
//   a  in  k  left operand
//   b  in  k  right operand
//   gt out 1  a > b (strict, unsigned)
// Each bit position decides "greater" when a has a 1 where b has a 0 and
// every more significant bit is equal; the result is the OR of those
// per-bit decisions, so there is no ripple dependency between bits.
module MagComp #(
  parameter int k = 8
) (
  input  logic [k-1:0] a,
  input  logic [k-1:0] b,
  output logic         gt
);

  logic [k-1:0] eq_bits;
  logic [k-1:0] gt_bits;

  assign eq_bits = ~(a ^ b);

  genvar gi;
  generate
    for (gi = 0; gi < k; gi++) begin : g_bit
      if (gi == k - 1) begin : g_msb
        assign gt_bits[gi] = a[gi] & ~b[gi];
      end else begin : g_lower
        assign gt_bits[gi] = a[gi] & ~b[gi] & (&eq_bits[k-1:gi+1]);
      end
    end
  endgenerate

  assign gt = |gt_bits;

endmodule

// File: rtl/best_move_sel.sv
// best_move_sel: sequential arg-max over one score per board cell.
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   start      in   begin a search (honoured only when idle)
//   occ        in   occupied-cell mask, captured on the accepted start
//   in_valid   in   in_score valid
//   in_ready   out  a score is accepted this cycle (SCAN only)
//   in_score   in   score for cell cnt, unsigned
//   busy       out  a search or result hand-off is in progress
//   out_valid  out  result available
//   out_ready  in   consumer takes the result
//   best_idx   out  winning cell index
//   best_score out  winning score
//   none       out  all cells occupied, no legal move
module best_move_sel
  import tictac_pkg::*;
#(
  parameter int W  = SCORE_W,
  parameter int N  = N_CELLS,
  parameter int IW = IDX_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  occ,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_score,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] best_idx,
  output logic [W-1:0]  best_score,
  output logic          none
);

  bms_state_t    state_reg, state_next;
  logic [IW-1:0] cnt_reg, cnt_next;
  logic          have_best_reg, have_best_next;
  logic [N-1:0]  occ_q_reg, occ_q_next;
  logic [IW-1:0] best_idx_reg, best_idx_next;
  logic [W-1:0]  best_score_reg, best_score_next;
  logic          none_reg, none_next;

  logic gt;
  logic beat;
  logic take;

  MagComp #(.k(W)) u_cmp (
    .a  (in_score),
    .b  (best_score_reg),
    .gt (gt)
  );

  assign beat = in_valid && (state_reg == SCAN);
  // A free cell wins outright when nothing is held yet, so a score of 0
  // still becomes the best; afterwards strict > keeps the lowest index on ties.
  assign take = beat && !occ_q_reg[cnt_reg] && (!have_best_reg || gt);

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    have_best_next  = have_best_reg;
    occ_q_next      = occ_q_reg;
    best_idx_next   = best_idx_reg;
    best_score_next = best_score_reg;
    none_next       = none_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          occ_q_next      = occ;
          cnt_next        = '0;
          have_best_next  = 1'b0;
          best_idx_next   = '0;
          best_score_next = '0;
          none_next       = 1'b0;
          state_next      = SCAN;
        end
      end
      SCAN: begin
        if (beat) begin
          if (take) begin
            best_score_next = in_score;
            best_idx_next   = cnt_reg;
            have_best_next  = 1'b1;
          end
          if (cnt_reg == IW'(N - 1)) begin
            // cnt stays at N-1 rather than wrapping
            state_next = DONE;
            none_next  = ~(have_best_reg | take);
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      have_best_reg  <= 1'b0;
      occ_q_reg      <= '0;
      best_idx_reg   <= '0;
      best_score_reg <= '0;
      none_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      have_best_reg  <= have_best_next;
      occ_q_reg      <= occ_q_next;
      best_idx_reg   <= best_idx_next;
      best_score_reg <= best_score_next;
      none_reg       <= none_next;
    end
  end

  assign in_ready   = (state_reg == SCAN);
  assign busy       = (state_reg != IDLE);
  assign out_valid  = (state_reg == DONE);
  assign best_idx   = best_idx_reg;
  assign best_score = best_score_reg;
  assign none       = none_reg;

endmodule

// File: tb/tb_best_move_sel.sv
module tb_best_move_sel;

  typedef struct packed {
    logic [3:0] idx;
    logic [7:0] score;
    logic       none;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] occ;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_score;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] best_idx;
  logic [7:0] best_score;
  logic       none;

  int checks = 0;
  int errors = 0;

  exp_t       exp_q[$];
  logic [7:0] sv [9];

  always #5 clk = ~clk;

  best_move_sel dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .occ        (occ),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_score   (in_score),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .best_idx   (best_idx),
    .best_score (best_score),
    .none       (none)
  );

  // Monitor: every cycle with out_valid the presented result must match the
  // scoreboard head; it is popped only when the consumer takes it.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got idx=%0d score=%0d none=%0d required no out_valid",
                 best_idx, best_score, none);
      end else begin
        if ({best_idx, best_score, none} !== {exp_q[0].idx, exp_q[0].score, exp_q[0].none}) begin
          errors++;
          $display("FAIL result got idx=%0d score=%0d none=%0d required idx=%0d score=%0d none=%0d",
                   best_idx, best_score, none, exp_q[0].idx, exp_q[0].score, exp_q[0].none);
        end
        if (out_ready) begin
          $display("RESULT idx=%0d score=%0d none=%0d", best_idx, best_score, none);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout got busy=1 required busy=0");
    end
  endtask

  task automatic run_search(input logic [8:0] o, input bit gaps, input bit bp, input exp_t e);
    wait_idle();
    exp_q.push_back(e);
    out_ready = !bp;
    start = 1'b1;
    occ   = o;
    @(posedge clk); #1;
    start = 1'b0;
    chk("scan_entry", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 9; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          start    = 1'b1;   // must be ignored while scanning
          @(posedge clk); #1;
          start    = 1'b0;
        end
      end
      in_valid = 1'b1;
      in_score = sv[i];
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (i < 8) chk("no_early_valid", {31'd0, out_valid}, 32'd0);
    end
    chk("done_latency", {31'd0, out_valid}, 32'd1);
    if (bp) begin
      repeat (5) begin
        start = 1'b1;        // ignored in DONE
        @(posedge clk); #1;
      end
      out_ready = 1'b1;      // handshake with start still high
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_in_done_ignored", {31'd0, busy}, 32'd0);
    end
    wait_idle();
    $display("SEARCH occ=%03h done", o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; occ = '0; in_valid = 1'b0; in_score = '0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",   {31'd0, in_ready},   32'd0);
    chk("rst_out_valid",  {31'd0, out_valid},  32'd0);
    chk("rst_busy",       {31'd0, busy},       32'd0);
    chk("rst_best_idx",   {28'd0, best_idx},   32'd0);
    chk("rst_best_score", {24'd0, best_score}, 32'd0);
    chk("rst_none",       {31'd0, none},       32'd0);
    start = 1'b1;
    @(posedge clk); #1;
    chk("start_under_rst", {31'd0, busy}, 32'd0);
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic arg-max; tie between cells 3 and 5 goes to 3
    sv = '{8'd3, 8'd7, 8'd1, 8'd9, 8'd2, 8'd9, 8'd0, 8'd4, 8'd5};
    run_search(9'h000, 1'b0, 1'b0, '{idx: 4'd3, score: 8'd9, none: 1'b0});
    chk("idle_hold_idx", {28'd0, best_idx}, 32'd3);

    // Occupied skip
    run_search(9'b000001000, 1'b0, 1'b0, '{idx: 4'd5, score: 8'd9, none: 1'b0});
    run_search(9'b000101000, 1'b0, 1'b0, '{idx: 4'd1, score: 8'd7, none: 1'b0});

    // All occupied
    run_search(9'h1FF, 1'b0, 1'b0, '{idx: 4'd0, score: 8'd0, none: 1'b1});

    // All-zero scores on a free board: cell 0 wins
    sv = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run_search(9'h000, 1'b0, 1'b0, '{idx: 4'd0, score: 8'd0, none: 1'b0});

    // Only cell 8 free with score 0: a zero score still beats "no best"
    run_search(9'h0FF, 1'b0, 1'b0, '{idx: 4'd8, score: 8'd0, none: 1'b0});

    // Unsigned comparison across the MSB
    sv = '{8'd100, 8'd200, 8'd255, 8'd128, 8'd0, 8'd254, 8'd127, 8'd1, 8'd255};
    run_search(9'h000, 1'b0, 1'b0, '{idx: 4'd2, score: 8'd255, none: 1'b0});

    // Bubbles, start pulses during SCAN/DONE, 5-cycle backpressure
    sv = '{8'd3, 8'd7, 8'd1, 8'd9, 8'd2, 8'd9, 8'd0, 8'd4, 8'd5};
    run_search(9'h000, 1'b1, 1'b1, '{idx: 4'd3, score: 8'd9, none: 1'b0});

    // Reset mid-SCAN after 4 beats: no result may appear
    out_ready = 1'b1;
    start = 1'b1; occ = 9'h000;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_score = 8'd50;
      @(posedge clk); #1;
    end
    in_score = 8'd250;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midscan_rst_busy",     {31'd0, busy},      32'd0);
    chk("midscan_rst_in_ready", {31'd0, in_ready},  32'd0);
    chk("midscan_rst_score",    {24'd0, best_score}, 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Fresh search after the abort starts from cell 0
    sv = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd6};
    run_search(9'h000, 1'b0, 1'b0, '{idx: 4'd8, score: 8'd6, none: 1'b0});
    sv = '{8'd3, 8'd7, 8'd1, 8'd9, 8'd2, 8'd9, 8'd0, 8'd4, 8'd5};
    run_search(9'h000, 1'b0, 1'b0, '{idx: 4'd3, score: 8'd9, none: 1'b0});

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
